// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style slave bus between two masters.
// Stalled transactions are aborted after TIMEOUT wait cycles with a bus error.
module bus_arbiter #(
   parameter int TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   input  logic [3:0]  m0_byteenable,
   output logic [31:0] m0_readdata,
   output logic        m0_waitrequest,
   output logic        m0_buserr,
   input  logic [31:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   input  logic [3:0]  m1_byteenable,
   output logic [31:0] m1_readdata,
   output logic        m1_waitrequest,
   output logic        m1_buserr,
   output logic [31:0] s_address,
   output logic        s_read,
   output logic        s_write,
   output logic [31:0] s_writedata,
   output logic [3:0]  s_byteenable,
   input  logic [31:0] s_readdata,
   input  logic        s_waitrequest,
   output logic [1:0]  grant
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1, ERR} state_t;

   state_t        state, state_nx;
   logic          last, last_nx;
   logic [CW-1:0] cnt;

   logic        req0, req1, gnt, own, tmo;
   logic        own_req, own_rd, own_wr;
   logic [31:0] own_addr, own_wd;
   logic [3:0]  own_be;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;
   assign gnt  = (state == GNT0) || (state == GNT1);

   // In ERR the owner is already latched into last
   assign own = (state == GNT1) ? 1'b1 :
                (state == GNT0) ? 1'b0 : last;

   assign tmo = s_waitrequest && (cnt == CW'(TIMEOUT - 1));

   always_comb begin
      own_req  = own ? req1 : req0;
      own_rd   = own ? m1_read : m0_read;
      own_wr   = own ? m1_write : m0_write;
      own_addr = own ? m1_address : m0_address;
      own_wd   = own ? m1_writedata : m0_writedata;
      own_be   = own ? m1_byteenable : m0_byteenable;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         last  <= last_nx;
         if (state == IDLE)
            cnt <= '0;
         else if (gnt && s_waitrequest && cnt != CW'(TIMEOUT))
            cnt <= cnt + CW'(1);
      end
   end

   always_comb begin
      state_nx = state;
      last_nx  = last;
      unique case (state)
         IDLE: begin
            if (req0 && req1)
               state_nx = last ? GNT0 : GNT1;
            else if (req0)
               state_nx = GNT0;
            else if (req1)
               state_nx = GNT1;
         end
         GNT0, GNT1: begin
            if (!own_req || !s_waitrequest) begin
               state_nx = IDLE;
               last_nx  = own;
            end else if (tmo) begin
               state_nx = ERR;
               last_nx  = own;
            end
         end
         ERR:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      s_address      = '0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      s_writedata    = '0;
      s_byteenable   = '0;
      m0_readdata    = '0;
      m1_readdata    = '0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      m0_buserr      = 1'b0;
      m1_buserr      = 1'b0;
      grant          = 2'b00;
      if (gnt) begin
         grant[own]   = 1'b1;
         s_address    = own_addr;
         s_read       = own_rd;
         s_write      = own_wr & ~own_rd;
         s_writedata  = own_wd;
         s_byteenable = own_be;
         if (own) begin
            m1_readdata    = s_readdata;
            m1_waitrequest = s_waitrequest;
         end else begin
            m0_readdata    = s_readdata;
            m0_waitrequest = s_waitrequest;
         end
      end else if (state == ERR) begin
         grant[own] = 1'b1;
         if (own) begin
            m1_waitrequest = 1'b0;
            m1_buserr      = 1'b1;
         end else begin
            m0_waitrequest = 1'b0;
            m0_buserr      = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_bus_arbiter;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr [2];
   logic        rd   [2];
   logic        wr   [2];
   logic [31:0] wd   [2];
   logic [3:0]  be   [2];
   logic [31:0] rdata[2];
   logic        wreq [2];
   logic        berr [2];
   logic [31:0] s_address, s_writedata, s_readdata;
   logic        s_read, s_write, s_waitrequest;
   logic [3:0]  s_byteenable;
   logic [1:0]  grant;

   int pass_cnt = 0;
   int total_cnt = 0;

   bus_arbiter #(.TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .m0_address(addr[0]), .m0_read(rd[0]), .m0_write(wr[0]),
      .m0_writedata(wd[0]), .m0_byteenable(be[0]),
      .m0_readdata(rdata[0]), .m0_waitrequest(wreq[0]), .m0_buserr(berr[0]),
      .m1_address(addr[1]), .m1_read(rd[1]), .m1_write(wr[1]),
      .m1_writedata(wd[1]), .m1_byteenable(be[1]),
      .m1_readdata(rdata[1]), .m1_waitrequest(wreq[1]), .m1_buserr(berr[1]),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
      .grant(grant)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Model: owner (-1 = none), whether the bus is in its abort cycle,
   // count of stalled granted cycles, and who was served last.
   int  m_owner;
   bit  m_err;
   int  m_stalls;
   int  m_last;
   bit  m_valid = 1'b0;

   logic [1:0]  e_grant;
   logic        e_sr, e_sw;
   logic [31:0] e_sa, e_swd;
   logic [3:0]  e_sbe;
   logic        e_wr [2];
   logic        e_be [2];
   logic [31:0] e_rd [2];

   always @(negedge clk) begin
      if (m_valid) begin
         e_grant = 2'b00;
         e_sr = 1'b0; e_sw = 1'b0;
         e_sa = '0; e_swd = '0; e_sbe = '0;
         for (int i = 0; i < 2; i++) begin
            e_wr[i] = 1'b1; e_be[i] = 1'b0; e_rd[i] = '0;
         end
         if (m_owner >= 0 && !m_err) begin
            e_grant[m_owner] = 1'b1;
            e_sa  = addr[m_owner];
            e_sr  = rd[m_owner];
            e_sw  = wr[m_owner] & ~rd[m_owner];
            e_swd = wd[m_owner];
            e_sbe = be[m_owner];
            e_rd[m_owner] = s_readdata;
            e_wr[m_owner] = s_waitrequest;
         end else if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_wr[m_owner] = 1'b0;
            e_be[m_owner] = 1'b1;
         end
         chk("mdl grant", 32'(grant), 32'(e_grant));
         chk("mdl s_read", 32'(s_read), 32'(e_sr));
         chk("mdl s_write", 32'(s_write), 32'(e_sw));
         chk("mdl s_address", s_address, e_sa);
         chk("mdl s_writedata", s_writedata, e_swd);
         chk("mdl s_byteenable", 32'(s_byteenable), 32'(e_sbe));
         for (int i = 0; i < 2; i++) begin
            chk("mdl waitrequest", 32'(wreq[i]), 32'(e_wr[i]));
            chk("mdl buserr", 32'(berr[i]), 32'(e_be[i]));
            chk("mdl readdata", rdata[i], e_rd[i]);
         end
      end
      if (reset) begin
         m_owner = -1; m_err = 1'b0; m_stalls = 0; m_last = 1;
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (m_owner < 0) begin
            m_stalls = 0;
            if ((rd[0] | wr[0]) && (rd[1] | wr[1])) m_owner = 1 - m_last;
            else if (rd[0] | wr[0]) m_owner = 0;
            else if (rd[1] | wr[1]) m_owner = 1;
         end else if (m_err) begin
            m_last = m_owner; m_owner = -1; m_err = 1'b0;
         end else if (!(rd[m_owner] | wr[m_owner]) || !s_waitrequest) begin
            m_last = m_owner; m_owner = -1;
         end else begin
            m_stalls++;
            if (m_stalls == TMO) m_err = 1'b1;
         end
      end
   end

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   logic [1:0] seq [5];

   initial begin
      seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         addr[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0; wd[i] = '0; be[i] = '0;
      end
      s_readdata = '0;
      s_waitrequest = 1'b1;
      cyc; cyc; #1;
      chk("rst grant", 32'(grant), 32'h0);
      chk("rst m0 wait", 32'(wreq[0]), 32'h1);
      chk("rst m1 wait", 32'(wreq[1]), 32'h1);
      chk("rst s_read", 32'(s_read), 32'h0);
      reset = 1'b0;

      // Single read with two wait cycles
      cyc; rd[0] = 1'b1; addr[0] = 32'h0000_1000; #1;
      chk("rd idle grant", 32'(grant), 32'h0);
      for (int i = 0; i < 2; i++) begin
         cyc; #1;
         chk("rd grant", 32'(grant), 32'h1);
         chk("rd s_address", s_address, 32'h0000_1000);
         chk("rd s_read", 32'(s_read), 32'h1);
         chk("rd m0 wait", 32'(wreq[0]), 32'h1);
      end
      cyc; s_waitrequest = 1'b0; s_readdata = 32'hDEAD_BEEF; #1;
      chk("rd done grant", 32'(grant), 32'h1);
      chk("rd done wait", 32'(wreq[0]), 32'h0);
      chk("rd done data", rdata[0], 32'hDEAD_BEEF);
      cyc; rd[0] = 1'b0; s_waitrequest = 1'b1; #1;
      chk("rd after grant", 32'(grant), 32'h0);
      chk("rd after wait", 32'(wreq[0]), 32'h1);

      // Both requesting right after reset
      cyc; reset = 1'b1;
      cyc; reset = 1'b0;
      wr[0] = 1'b1; wd[0] = 32'h1111_1111; addr[0] = 32'h0000_2000;
      rd[1] = 1'b1; addr[1] = 32'h0000_3000;
      s_waitrequest = 1'b0; #1;
      chk("rr idle grant", 32'(grant), 32'h0);
      for (int i = 0; i < 5; i++) begin
         cyc; #1;
         chk("rr grant seq", 32'(grant), 32'(seq[i]));
         if (i == 0) begin
            chk("rr s_write", 32'(s_write), 32'h1);
            chk("rr s_writedata", s_writedata, 32'h1111_1111);
         end
         if (i == 2) begin
            chk("rr s_read", 32'(s_read), 32'h1);
            chk("rr s_address", s_address, 32'h0000_3000);
         end
      end
      cyc; wr[0] = 1'b0; rd[1] = 1'b0; s_waitrequest = 1'b1; #1;
      chk("rr end grant", 32'(grant), 32'h0);

      // Byte write from master 1
      cyc; wr[1] = 1'b1; be[1] = 4'b0100; wd[1] = 32'h00AB_0000;
      addr[1] = 32'h0000_4000; #1;
      chk("bw idle m0 wait", 32'(wreq[0]), 32'h1);
      cyc; #1;
      chk("bw grant", 32'(grant), 32'h2);
      chk("bw s_byteenable", 32'(s_byteenable), 32'h4);
      chk("bw s_writedata", s_writedata, 32'h00AB_0000);
      chk("bw s_write", 32'(s_write), 32'h1);
      chk("bw m0 wait", 32'(wreq[0]), 32'h1);
      cyc; s_waitrequest = 1'b0; #1;
      chk("bw m1 done", 32'(wreq[1]), 32'h0);
      chk("bw m0 wait2", 32'(wreq[0]), 32'h1);
      cyc; wr[1] = 1'b0; s_waitrequest = 1'b1; #1;
      chk("bw idle be", 32'(s_byteenable), 32'h0);

      // Timeout on a stuck slave, m1 waits then gets the bus
      cyc; rd[0] = 1'b1; addr[0] = 32'h0000_5000;
      s_readdata = 32'h1234_5678; #1;
      chk("to idle grant", 32'(grant), 32'h0);
      for (int i = 0; i < TMO; i++) begin
         cyc;
         if (i == 1) rd[1] = 1'b1;
         #1;
         chk("to grant", 32'(grant), 32'h1);
         chk("to no err", 32'(berr[0]), 32'h0);
         chk("to m0 wait", 32'(wreq[0]), 32'h1);
      end
      cyc; #1;
      chk("to err wait", 32'(wreq[0]), 32'h0);
      chk("to err buserr", 32'(berr[0]), 32'h1);
      chk("to err data", rdata[0], 32'h0);
      chk("to err s_read", 32'(s_read), 32'h0);
      chk("to err grant", 32'(grant), 32'h1);
      chk("to err m1 wait", 32'(wreq[1]), 32'h1);
      cyc; rd[0] = 1'b0; #1;
      chk("to idle2 grant", 32'(grant), 32'h0);
      chk("to idle2 buserr", 32'(berr[0]), 32'h0);
      cyc; s_waitrequest = 1'b0; #1;
      chk("to m1 grant", 32'(grant), 32'h2);
      chk("to m1 data", rdata[1], 32'h1234_5678);
      cyc; rd[1] = 1'b0; s_waitrequest = 1'b1; #1;
      chk("to end grant", 32'(grant), 32'h0);

      // Release in the last wait cycle before the abort
      cyc; rd[0] = 1'b1; #1;
      for (int i = 0; i < TMO - 1; i++) begin
         cyc; #1;
         chk("bd grant", 32'(grant), 32'h1);
         chk("bd m0 wait", 32'(wreq[0]), 32'h1);
      end
      cyc; s_waitrequest = 1'b0; #1;
      chk("bd done wait", 32'(wreq[0]), 32'h0);
      chk("bd done buserr", 32'(berr[0]), 32'h0);
      chk("bd done grant", 32'(grant), 32'h1);
      cyc; rd[0] = 1'b0; s_waitrequest = 1'b1; #1;
      chk("bd after grant", 32'(grant), 32'h0);
      chk("bd after buserr", 32'(berr[0]), 32'h0);

      // Reset while master 1 is stalled
      cyc; rd[1] = 1'b1; addr[1] = 32'h0000_6000; #1;
      cyc; #1;
      chk("mr grant", 32'(grant), 32'h2);
      cyc; reset = 1'b1; #1;
      chk("mr grant2", 32'(grant), 32'h2);
      cyc; reset = 1'b0; #1;
      chk("mr rst grant", 32'(grant), 32'h0);
      chk("mr rst wait", 32'(wreq[1]), 32'h1);
      chk("mr rst buserr", 32'(berr[1]), 32'h0);
      chk("mr rst s_read", 32'(s_read), 32'h0);
      chk("mr rst s_addr", s_address, 32'h0);
      cyc; rd[1] = 1'b0; #1;
      chk("mr drop buserr", 32'(berr[1]), 32'h0);
      cyc; cyc;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
